// File: rtl/vga_csel_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_csel_debounce_pkg
//  Purpose  : Shared constants and types for the VGA colour-select front end:
//             dot-clock rate, sync polarities, default debounce length and
//             the colour-select vector type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vga_csel_debounce_pkg;

    // Dot clock of the VGA pipeline; all timing constants derive from it.
    localparam int unsigned C_DOTCLK_HZ = 25_000_000;

    // Sync polarities as driven by the encoder (0 = active-low).
    localparam bit C_VGA_HSYNC_POL = 1'b0;
    localparam bit C_VGA_VSYNC_POL = 1'b0;

    // 10 ms of stability at the dot clock before a switch change is believed.
    localparam int unsigned C_DEBOUNCE_CYCLES = C_DOTCLK_HZ / 100;
    localparam int unsigned C_DEBOUNCE_CNT_W  = 18;

    localparam int unsigned C_CSEL_W = 8;

    typedef logic [C_CSEL_W-1:0] csel_t;

endpackage : vga_csel_debounce_pkg
`default_nettype wire

// File: rtl/vga_csel_debounce_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce
//  Purpose  : Single-bit debouncer. Q follows D only after D has differed
//             from Q on DEBOUNCE_CYCLES consecutive rising edges; any sample
//             equal to Q restarts the count, so short glitches are rejected.
//  Ports    : CLK  in  dot clock
//             RST  in  synchronous reset, active-high
//             D    in  synchronised raw switch bit
//             Q    out debounced bit (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter bit          RST_VAL         = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    // Terminal count: the edge that sees this count with D still different
    // is the DEBOUNCE_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_q   <= RST_VAL;
        end else if (D == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == C_CNT_MAX) begin
            r_q   <= D;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Q = r_q;

endmodule : switch_debounce
`default_nettype wire

// File: rtl/vga_csel_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : vga_csel_debounce
//  Purpose  : Debounces the 8 synchronised colour-select switches and applies
//             the debounced value to CSEL only at the start of vertical sync,
//             so a colour change never tears mid-frame.
//  Ports    : CLK       in   25 MHz dot clock
//             RST       in   synchronous reset, active-high
//             SW[7:0]   in   switch bits, already synchronised to CLK
//             VSYNC     in   vertical sync, active level = VSYNC_POL
//             CSEL[7:0] out  frame-aligned debounced colour select
//             CSEL_UPD  out  one-cycle pulse when CSEL changes value
//             PENDING   out  debounced value differs from CSEL
//  Revision : 1.0 - initial release
// ============================================================================
module vga_csel_debounce
    import vga_csel_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = C_DEBOUNCE_CNT_W,
    parameter logic [7:0]  RESET_CSEL      = 8'h00,
    parameter bit          VSYNC_POL       = C_VGA_VSYNC_POL
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SW,
    input  logic       VSYNC,
    output logic [7:0] CSEL,
    output logic       CSEL_UPD,
    output logic       PENDING
);

    csel_t w_stable;
    csel_t r_csel;
    logic  r_csel_upd;
    logic  r_pending;
    logic  r_vs_q;
    logic  w_vs_start;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RST_VAL         (RESET_CSEL[gi])
        ) u_switch_debounce (
            .CLK (CLK),
            .RST (RST),
            .D   (SW[gi]),
            .Q   (w_stable[gi])
        );
    end

    // Leading edge of the active VSYNC level. The history register resets to
    // the inactive level so a VSYNC already active at reset release still
    // counts as a genuine frame start rather than being missed.
    assign w_vs_start = (r_vs_q == ~VSYNC_POL) && (VSYNC == VSYNC_POL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vs_q     <= ~VSYNC_POL;
            r_csel     <= RESET_CSEL;
            r_csel_upd <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_vs_q <= VSYNC;
            // w_stable here is the pre-edge value: a debounced change landing
            // on the same edge as the frame start waits one more frame.
            if (w_vs_start) begin
                r_csel     <= w_stable;
                r_csel_upd <= (w_stable != r_csel);
            end else begin
                r_csel_upd <= 1'b0;
            end
            r_pending <= (w_stable != r_csel);
        end
    end

    assign CSEL     = r_csel;
    assign CSEL_UPD = r_csel_upd;
    assign PENDING  = r_pending;

endmodule : vga_csel_debounce
`default_nettype wire
